// File: rtl/sram_req_tracker.sv
// Request/response tracker between a CPU pipeline stage and one SRAM-like bridge port.
// Gates requests on outstanding count, drops responses cancelled by flush, buffers unconsumed data.
module sram_req_tracker #(
  parameter int MAX_OUT = 2,
  parameter int CW      = 3
) (
  input  logic        aclk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_addr_ok,
  output logic        cpu_data_ok,
  output logic [31:0] cpu_rdata,
  input  logic        cpu_rready,
  input  logic        flush,
  output logic        sram_req,
  output logic        sram_wr,
  output logic [1:0]  sram_size,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic [3:0]  sram_wstrb,
  input  logic        sram_addr_ok,
  input  logic        sram_data_ok,
  input  logic [31:0] sram_rdata,
  output logic        busy
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [CW-1:0] out_cnt;
  logic [CW-1:0] cancel_cnt;
  logic [CW-1:0] fifo_cnt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_mem [MAX_OUT];

  logic [CW:0] occupancy;
  logic        ret;
  logic        keep;
  logic        fifo_empty;
  logic        push;
  logic        pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  // Cancelled requests still occupy out_cnt, so the gate also leaves room for their responses.
  assign occupancy = {1'b0, out_cnt} + {1'b0, fifo_cnt};
  assign sram_req  = !reset && cpu_req && !flush && (occupancy < (CW+1)'(MAX_OUT));

  assign sram_wr    = cpu_wr;
  assign sram_size  = cpu_size;
  assign sram_addr  = cpu_addr;
  assign sram_wdata = cpu_wdata;
  assign sram_wstrb = cpu_wstrb;

  assign cpu_addr_ok = sram_req && sram_addr_ok;

  // A data_ok with nothing outstanding is a bridge protocol error and is ignored entirely.
  assign ret        = sram_data_ok && (out_cnt != '0);
  assign keep       = ret && !flush && (cancel_cnt == '0);
  assign fifo_empty = (fifo_cnt == '0);

  assign cpu_data_ok = !reset && !flush && (keep || !fifo_empty);
  assign cpu_rdata   = fifo_empty ? sram_rdata : fifo_mem[rd_ptr];

  assign push = keep && !(fifo_empty && cpu_rready);
  assign pop  = !reset && !flush && !fifo_empty && cpu_rready;

  assign busy = (out_cnt != '0) || !fifo_empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (reset) begin
      out_cnt    <= '0;
      cancel_cnt <= '0;
      fifo_cnt   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      case ({cpu_addr_ok, ret})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase

      if (flush) begin
        cancel_cnt <= out_cnt - CW'(ret);
      end else if (ret && (cancel_cnt != '0)) begin
        cancel_cnt <= cancel_cnt - CW'(1);
      end

      if (flush) begin
        fifo_cnt <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        case ({push, pop})
          2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
          2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
          default: fifo_cnt <= fifo_cnt;
        endcase
      end
    end
  end

  // NOTE: the data array has no reset; fifo_cnt alone decides which entries are meaningful.
  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr] <= sram_rdata;
  end

endmodule

// File: tb/tb_sram_req_tracker.sv
// Directed bench for sram_req_tracker: stimulus pushes expected read data into a scoreboard,
// a negedge monitor pops and compares each consumed response.
module tb_sram_req_tracker;

  logic        aclk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_wr;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_addr_ok;
  logic        cpu_data_ok;
  logic [31:0] cpu_rdata;
  logic        cpu_rready;
  logic        flush;
  logic        sram_req;
  logic        sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wstrb;
  logic        sram_addr_ok;
  logic        sram_data_ok;
  logic [31:0] sram_rdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  always #5 aclk = ~aclk;

  sram_req_tracker #(.MAX_OUT(2), .CW(3)) dut (
    .aclk        (aclk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .cpu_wr      (cpu_wr),
    .cpu_size    (cpu_size),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wstrb   (cpu_wstrb),
    .cpu_addr_ok (cpu_addr_ok),
    .cpu_data_ok (cpu_data_ok),
    .cpu_rdata   (cpu_rdata),
    .cpu_rready  (cpu_rready),
    .flush       (flush),
    .sram_req    (sram_req),
    .sram_wr     (sram_wr),
    .sram_size   (sram_size),
    .sram_addr   (sram_addr),
    .sram_wdata  (sram_wdata),
    .sram_wstrb  (sram_wstrb),
    .sram_addr_ok(sram_addr_ok),
    .sram_data_ok(sram_data_ok),
    .sram_rdata  (sram_rdata),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: every response the pipeline consumes must match the scoreboard head.
  always @(negedge aclk) begin
    if (!reset && cpu_data_ok && cpu_rready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got response 0x%08h with no expected entry", cpu_rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (cpu_rdata !== e) begin
          failures++;
          $display("FAIL sb_rdata: got 0x%08h expected 0x%08h", cpu_rdata, e);
        end
      end
    end
  end

  // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
  task automatic next_cycle();
    @(posedge aclk);
    #1;
    cpu_req      = 1'b0;
    sram_addr_ok = 1'b0;
    sram_data_ok = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic mid();
    @(negedge aclk);
  endtask

  task automatic accept(input logic [31:0] addr);
    next_cycle();
    cpu_req      = 1'b1;
    cpu_addr     = addr;
    sram_addr_ok = 1'b1;
    mid();
    check("accept_addr_ok", cpu_addr_ok, 1);
  endtask

  task automatic respond(input logic [31:0] data, input logic expect_kept);
    next_cycle();
    sram_data_ok = 1'b1;
    sram_rdata   = data;
    if (expect_kept) exp_q.push_back(data);
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'd2; cpu_addr = '0;
    cpu_wdata = 32'h1234_5678; cpu_wstrb = 4'hF; cpu_rready = 1'b1; flush = 1'b0;
    sram_addr_ok = 1'b1; sram_data_ok = 1'b0; sram_rdata = '0;
    mid();
    check("reset_sram_req_forced", sram_req, 0);
    check("reset_addr_ok_forced", cpu_addr_ok, 0);
    @(posedge aclk); #1;
    reset = 1'b0; cpu_req = 1'b0; sram_addr_ok = 1'b0;
    mid();
    check("reset_busy", busy, 0);
    check("reset_data_ok", cpu_data_ok, 0);

    // Single read with zero-latency bypass on return.
    accept(32'h1FC0_0000);
    check("single_sram_addr", sram_addr, 32'h1FC0_0000);
    check("single_wdata_thru", sram_wdata, 32'h1234_5678);
    next_cycle(); mid(); check("single_busy_c1", busy, 1);
    next_cycle(); mid(); check("single_no_data_c2", cpu_data_ok, 0);
    respond(32'h3C1D_0000, 1'b1); mid();
    check("single_data_ok_c3", cpu_data_ok, 1);
    check("single_rdata_c3", cpu_rdata, 32'h3C1D_0000);
    next_cycle(); mid(); check("single_busy_after", busy, 0);

    // Outstanding limit at MAX_OUT=2.
    accept(32'h0000_1000);
    accept(32'h0000_1004);
    next_cycle(); cpu_req = 1'b1; sram_addr_ok = 1'b1; mid();
    check("limit_sram_req_blocked", sram_req, 0);
    check("limit_addr_ok_blocked", cpu_addr_ok, 0);
    respond(32'h0000_0011, 1'b1); cpu_req = 1'b1; mid();
    next_cycle(); cpu_req = 1'b1; mid();
    check("limit_sram_req_reopen", sram_req, 1);
    respond(32'h0000_0022, 1'b1); mid();
    next_cycle(); mid(); check("limit_busy_after", busy, 0);

    // Back-pressure: both responses buffered, then drained in order.
    cpu_rready = 1'b0;
    accept(32'h0000_2000);
    accept(32'h0000_2004);
    respond(32'h0000_000A, 1'b1); mid();
    check("bp_bypass_presented", cpu_data_ok, 1);
    respond(32'h0000_000B, 1'b1); mid();
    check("bp_head_rdata", cpu_rdata, 32'h0000_000A);
    next_cycle(); cpu_req = 1'b1; mid();
    check("bp_sram_req_blocked", sram_req, 0);
    check("bp_fifo_cnt", 32'(dut.fifo_cnt), 2);
    next_cycle(); cpu_rready = 1'b1; mid();
    check("bp_pop_a_valid", cpu_data_ok, 1);
    next_cycle(); mid();
    check("bp_pop_b_valid", cpu_data_ok, 1);
    next_cycle(); mid(); check("bp_busy_after", busy, 0);

    // Flush with two requests in flight.
    accept(32'h0000_3000);
    accept(32'h0000_3004);
    next_cycle(); flush = 1'b1; cpu_req = 1'b1; mid();
    check("flush_req_not_fwd", sram_req, 0);
    respond(32'hBAD0_0001, 1'b0); mid();
    check("flush_cancel_2", 32'(dut.cancel_cnt), 2);
    check("flush_drop1_data_ok", cpu_data_ok, 0);
    respond(32'hBAD0_0002, 1'b0); mid();
    check("flush_cancel_1", 32'(dut.cancel_cnt), 1);
    check("flush_drop2_data_ok", cpu_data_ok, 0);
    next_cycle(); mid();
    check("flush_cancel_0", 32'(dut.cancel_cnt), 0);
    check("flush_busy_after", busy, 0);
    accept(32'h0000_3100);
    respond(32'h0000_0055, 1'b1); mid();
    check("flush_new_data_ok", cpu_data_ok, 1);

    // Flush coincident with a response while two are outstanding.
    accept(32'h0000_4000);
    accept(32'h0000_4004);
    respond(32'hDEAD_0000, 1'b0); flush = 1'b1; mid();
    check("coinc_drop_data_ok", cpu_data_ok, 0);
    next_cycle(); mid();
    check("coinc_cancel_1", 32'(dut.cancel_cnt), 1);
    check("coinc_out_cnt_1", 32'(dut.out_cnt), 1);
    respond(32'hBEEF_0000, 1'b0); mid();
    check("coinc_drop2_data_ok", cpu_data_ok, 0);
    next_cycle(); mid();
    check("coinc_busy_after", busy, 0);

    // Reset with one request in flight and one response buffered.
    cpu_rready = 1'b0;
    accept(32'h0000_5000);
    accept(32'h0000_5004);
    respond(32'h0000_0077, 1'b0); mid();
    next_cycle(); reset = 1'b1; cpu_req = 1'b1; sram_addr_ok = 1'b1; mid();
    check("rst_mid_data_ok", cpu_data_ok, 0);
    check("rst_mid_sram_req", sram_req, 0);
    next_cycle(); reset = 1'b0; cpu_rready = 1'b1; mid();
    check("rst_out_cnt", 32'(dut.out_cnt), 0);
    check("rst_fifo_cnt", 32'(dut.fifo_cnt), 0);
    check("rst_busy", busy, 0);
    check("rst_data_ok", cpu_data_ok, 0);

    // Stray data_ok with nothing outstanding is ignored.
    respond(32'h0BAD_0BAD, 1'b0); mid();
    check("stray_data_ok", cpu_data_ok, 0);
    next_cycle(); mid();
    check("stray_busy", busy, 0);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
